// File: rtl/btn_irq_source_if.sv
// btn_irq_source_if
//   Groups the event / interrupt handshake signals of btn_irq_source.
//   master : the side that drives events and the CPU handshake (wrapper / bench)
//   slave  : btn_irq_source itself
// Signals:
//   evt_tick  one-cycle debounced button event
//   irq_en    interrupt enable (mask)
//   irq_ack   CPU acknowledge, level
//   ovf_clr   one-cycle clear of the sticky overflow flag
//   irq       interrupt request, level
//   pend_cnt  number of pending events
//   ovf       sticky overflow flag
//   led       stretched event indicator
interface btn_irq_source_if #(
    parameter int unsigned CNT_W = 4
);
    logic             evt_tick;
    logic             irq_en;
    logic             irq_ack;
    logic             ovf_clr;
    logic             irq;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;
    logic             led;

    modport master (
        output evt_tick, irq_en, irq_ack, ovf_clr,
        input  irq, pend_cnt, ovf, led
    );

    modport slave (
        input  evt_tick, irq_en, irq_ack, ovf_clr,
        output irq, pend_cnt, ovf, led
    );
endinterface

// File: rtl/btn_irq_source.sv
// btn_irq_source
//   Counts debounced button events as pending interrupts and presents them to
//   the CPU as a level irq with a four-phase ack handshake: each ack high phase
//   retires exactly one event. A sticky flag records events lost when the
//   counter is saturated, and an LED is stretched for a visible period per event.
// Ports:
//   clk_50MHz  system clock
//   rst_n      asynchronous active-low reset
//   bus        btn_irq_source_if.slave (evt_tick, irq_en, irq_ack, ovf_clr in;
//              irq, pend_cnt, ovf, led out)
// All outputs come straight from flops (irq is a decode of the state register),
// so there is no combinational input-to-output path.
module btn_irq_source #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned STRETCH_N = 22
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    btn_irq_source_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] ACKED = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]           state_q,   state_d;
    logic [CNT_W-1:0]     pend_q,    pend_d;
    logic                 ovf_q,     ovf_d;
    logic [STRETCH_N-1:0] stretch_q, stretch_d;
    logic                 led_q,     led_d;

    logic retire;
    logic ovf_set;

    // One event retires only on the REQ -> ACKED transition; irq_en low wins.
    assign retire = (state_q == REQ) && bus.irq_en && bus.irq_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.irq_en && (pend_q != '0)) state_d = REQ;
            REQ: begin
                if (!bus.irq_en)      state_d = IDLE;
                else if (bus.irq_ack) state_d = ACKED;
            end
            ACKED:   if (!bus.irq_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (bus.evt_tick && !retire) begin
            if (pend_q == '1) ovf_set = 1'b1;
            else              pend_d  = pend_q + CNT_ONE;
        end else if (retire && !bus.evt_tick) begin
            pend_d = pend_q - CNT_ONE;
        end
    end

    // Set has priority over a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set)          ovf_d = 1'b1;
        else if (bus.ovf_clr) ovf_d = 1'b0;
    end

    // The led flop looks at the event itself plus the pre-edge counter, so it
    // rises on the event edge and stays high for the full 2^STRETCH_N cycles.
    always_comb begin
        stretch_d = stretch_q;
        if (bus.evt_tick)         stretch_d = '1;
        else if (stretch_q != '0) stretch_d = stretch_q - 1'b1;
        led_d = bus.evt_tick || (stretch_q != '0);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            stretch_q <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            stretch_q <= stretch_d;
            led_q     <= led_d;
        end
    end

    assign bus.irq      = (state_q == REQ);
    assign bus.pend_cnt = pend_q;
    assign bus.ovf      = ovf_q;
    assign bus.led      = led_q;

endmodule
